task4_fir: RTL and testbench
============================

Name: task4_fir

Overview:
- Four-tap, direct-form, transposition-free FIR filter for signed 8-bit samples. Produces a registered signed 16-bit output.
- Accepts one sample per clock; there is no handshake and every clock edge is a sample.
- Sits between a sample source and downstream DSP/monitor logic as a fixed-coefficient smoothing filter.

Parameters:
- COEF0, 8'sd1, signed 8-bit coefficient applied to the current sample x(n)
- COEF1, 8'sd2, signed 8-bit coefficient applied to x(n-1)
- COEF2, 8'sd3, signed 8-bit coefficient applied to x(n-2)
- COEF3, 8'sd4, signed 8-bit coefficient applied to x(n-3)

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
- x_in  input  8  signed two's-complement input sample, sampled every rising edge
- y_out  output  16  signed two's-complement filtered output, registered

Behaviour:
- Interface (already decided): one clock, clk. Reset rst_n is synchronous and active-low.
- Reset: on a rising edge with rst_n=0, clear the delay registers d0, d1 and d2 and y_out to 0. Reset overrides any sample on that edge. Asserting reset mid-stream discards all history.
- Delay line, on each rising edge with rst_n=1:
  - d0 <= x_in
  - d1 <= d0
  - d2 <= d1
- Output, on the same edge: y_out <= sat16(COEF0*x_in + COEF1*d0 + COEF2*d1 + COEF3*d2). This uses the pre-edge values of d0, d1 and d2.
- Transfer function: y(n) = sum over k=0..3 of COEFk*x(n-k), where x(n) is x_in sampled at edge n.
- Latency: the output register updates on the same edge that samples x_in. x_in applied before edge n is reflected in y_out after edge n. Impulse response length is 4 samples.
- Arithmetic:
  - Each product is signed 8x8, giving 16 bits.
  - Accumulate in at least 18-bit signed without intermediate truncation.
  - All operands are treated as signed; no unsigned promotion.
- Saturation:
  - Accumulator above 32767 gives y_out = 32767.
  - Accumulator below -32768 gives y_out = -32768.
  - Otherwise y_out is the exact sum.
  - With the default coefficients the maximum |sum| is 1280, so saturation never triggers.
- No rounding and no output scaling.
- The design is fully synchronous, with no combinational path from x_in to y_out.
- Coefficients are elaboration-time constants; there is no runtime coefficient load.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with x_in=8'sd5 -> y_out=0 and the delay line is clear. The first edge after release with x_in=0 gives y_out=0.
- Ramp: after reset apply x_in=1,2,3,4 then 0 held.
  - Edge-by-edge y_out: 1, 4, 10, 20, 25, 24, 16, then 0 from then on.
- Impulse: a single x_in=1 followed by zeros -> y_out=1,2,3,4,0.
- Negative full-scale: x_in=-128 held -> y_out=-128, -384, -768, -1280, then stays -1280.
- Saturation, with all COEFk=8'sd127:
  - x_in=127 held -> the fourth output is 32767 (the exact value 64516 is clamped).
  - x_in=-128 held -> the third output is -32768 (the exact value -48768 is clamped).
- Mid-stream reset: during the ramp, pull rst_n low for one edge at x_in=3 -> y_out=0. Then apply x_in=4 -> y_out=4, with no prior history contributing.

Source files
------------

// File: rtl/task4_fir.sv
// Four-tap fixed-coefficient FIR for signed 8-bit samples.
// Registered output saturates to the signed 16-bit range.
module task4_fir #(
  parameter logic signed [7:0] COEF0 = 8'sd1,
  parameter logic signed [7:0] COEF1 = 8'sd2,
  parameter logic signed [7:0] COEF2 = 8'sd3,
  parameter logic signed [7:0] COEF3 = 8'sd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  x_in,
  output logic [15:0] y_out
);

  localparam logic signed [17:0] MAX = 18'sd32767;
  localparam logic signed [17:0] MIN = -18'sd32768;

  logic signed [7:0]  x;
  logic signed [7:0]  d0;
  logic signed [7:0]  d1;
  logic signed [7:0]  d2;
  logic signed [15:0] p0;
  logic signed [15:0] p1;
  logic signed [15:0] p2;
  logic signed [15:0] p3;
  logic signed [17:0] acc;
  logic signed [15:0] sat;

  assign x  = $signed(x_in);
  assign p0 = COEF0 * x;
  assign p1 = COEF1 * d0;
  assign p2 = COEF2 * d1;
  assign p3 = COEF3 * d2;

  // 18 bits hold four full-scale 8x8 products without overflow
  assign acc = 18'(p0) + 18'(p1) + 18'(p2) + 18'(p3);

  always_comb begin
    sat = acc[15:0];
    if (acc > MAX)
      sat = 16'sh7fff;
    else if (acc < MIN)
      sat = -16'sh8000;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d0    <= '0;
      d1    <= '0;
      d2    <= '0;
      y_out <= '0;
    end else begin
      d0    <= x;
      d1    <= d0;
      d2    <= d1;
      y_out <= sat;
    end
  end

endmodule

// File: tb/tb_task4_fir.sv
// Directed bench for task4_fir: default taps plus a 127-tap
// instance to exercise both saturation limits.
module tb_task4_fir;

  logic        clk;
  logic        rst_n;
  logic [7:0]  x_in;
  logic [15:0] y_out;
  logic [15:0] y_sat;

  int vectors;
  int miscompares;

  task4_fir dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x_in  (x_in),
    .y_out (y_out)
  );

  task4_fir #(
    .COEF0 (8'sd127),
    .COEF1 (8'sd127),
    .COEF2 (8'sd127),
    .COEF3 (8'sd127)
  ) sat (
    .clk   (clk),
    .rst_n (rst_n),
    .x_in  (x_in),
    .y_out (y_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d",
               tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic step(
    input logic signed [7:0] xv,
    input logic              r
  );
    x_in  = xv;
    rst_n = r;
    @(posedge clk);
    #1;
  endtask

  int ramp_x[8] = '{1, 2, 3, 4, 0, 0, 0, 0};
  int ramp_y[8] = '{1, 4, 10, 20, 25, 24, 16, 0};
  int imp_y[5]  = '{1, 2, 3, 4, 0};
  int neg_y[5]  = '{-128, -384, -768, -1280, -1280};
  int sp_y[4]   = '{16129, 32258, 32767, 32767};
  int sn_y[3]   = '{-16256, -32512, -32768};

  initial begin
    vectors     = 0;
    miscompares = 0;
    x_in        = '0;
    rst_n       = 1'b0;
    #2;

    step(8'sd5, 1'b0);
    check("rst0", y_out, 16'd0);
    step(8'sd5, 1'b0);
    check("rst1", y_out, 16'd0);
    check("rst_sat", y_sat, 16'd0);
    step(8'sd0, 1'b1);
    check("rel", y_out, 16'd0);

    for (int i = 0; i < 8; i++) begin
      step(8'(ramp_x[i]), 1'b1);
      check($sformatf("ramp%0d", i), y_out, 16'(ramp_y[i]));
    end

    for (int i = 0; i < 5; i++) begin
      step((i == 0) ? 8'sd1 : 8'sd0, 1'b1);
      check($sformatf("imp%0d", i), y_out, 16'(imp_y[i]));
    end

    for (int i = 0; i < 5; i++) begin
      step(-8'sd128, 1'b1);
      check($sformatf("neg%0d", i), y_out, 16'(neg_y[i]));
    end

    step(8'sd0, 1'b0);
    check("rst_a", y_sat, 16'd0);
    for (int i = 0; i < 4; i++) begin
      step(8'sd127, 1'b1);
      check($sformatf("satp%0d", i), y_sat, 16'(sp_y[i]));
    end

    step(8'sd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(-8'sd128, 1'b1);
      check($sformatf("satn%0d", i), y_sat, 16'(sn_y[i]));
    end

    step(8'sd0, 1'b0);
    step(8'sd1, 1'b1);
    check("mid0", y_out, 16'd1);
    step(8'sd2, 1'b1);
    check("mid1", y_out, 16'd4);
    step(8'sd3, 1'b0);
    check("mid_rst", y_out, 16'd0);
    step(8'sd4, 1'b1);
    check("mid_post", y_out, 16'd4);
    step(8'sd0, 1'b1);
    check("mid_tail", y_out, 16'd8);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
